// File: rtl/seg_display_scanner_pkg.sv
// Shared types and pin constants for the 4-digit 7-segment scanner.
// Anode and cathode values are active-low pin levels.
package seg_display_scanner_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b0111;
  localparam logic [3:0] AN_D1  = 4'b1011;
  localparam logic [3:0] AN_D2  = 4'b1101;
  localparam logic [3:0] AN_D3  = 4'b1110;

  localparam logic [6:0] CATH_OFF = 7'h7F;

  function automatic logic [3:0] an_sel(
    input digit_idx_t i
  );
    logic [3:0] a;
    a = AN_OFF;
    unique case (i)
      2'd0: a = AN_D0;
      2'd1: a = AN_D1;
      2'd2: a = AN_D2;
      2'd3: a = AN_D3;
    endcase
    return a;
  endfunction

  function automatic logic [6:0] seg_of(
    input logic [27:0] arr,
    input digit_idx_t  i
  );
    logic [6:0] s;
    s = arr[6:0];
    unique case (i)
      2'd0: s = arr[27:21];
      2'd1: s = arr[20:14];
      2'd2: s = arr[13:7];
      2'd3: s = arr[6:0];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_scanner_scan_prescaler.sv
// Slot counter and digit/frame sequencer for the display scanner.
// Everything clears while enable is low so a restart begins at digit 0.
module scan_prescaler
  import seg_display_scanner_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       slot_zero,
  output logic       in_guard,
  output digit_idx_t digit_idx,
  output logic       frame_wrap
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic          slot_last;

  always_comb begin
    slot_last = (cnt_q == SLOT_LAST);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_last) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign slot_zero  = (cnt_q == '0);
  assign in_guard   = (cnt_q < GUARD_LIM);
  assign digit_idx  = idx_q;
  assign frame_wrap = enable && slot_last && (idx_q == 2'd3);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 4-digit display driver with
// per-digit blink, guard interval and frame-coherent snapshot.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [27:0] seg_array,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  cathode,
  output logic        frame_start
);

  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic       slot_zero;
  logic       in_guard;
  digit_idx_t digit_idx;
  logic       frame_wrap;

  scan_prescaler #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (resetn),
    .enable    (enable),
    .slot_zero (slot_zero),
    .in_guard  (in_guard),
    .digit_idx (digit_idx),
    .frame_wrap(frame_wrap)
  );

  logic [27:0]   seg_sh_q, seg_sh_d;
  logic [3:0]    mask_sh_q, mask_sh_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    cath_q, cath_d;
  logic          fs_q, fs_d;
  logic          snap;
  logic          blank;

  always_comb begin
    snap      = enable && slot_zero && (digit_idx == 2'd0);
    seg_sh_d  = snap ? seg_array : seg_sh_q;
    mask_sh_d = snap ? blink_mask : mask_sh_q;

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!enable) begin
      blink_cnt_d = '0;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // mask bit 3 belongs to digit 0, so index with the inverted digit
    blank = mask_sh_q[~digit_idx] && phase_q;
    an_d  = AN_OFF;
    if (enable && !in_guard && !blank) begin
      an_d = an_sel(digit_idx);
    end
    cath_d = enable ? ~seg_of(seg_sh_d, digit_idx) : CATH_OFF;
    fs_d   = snap;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_sh_q    <= '0;
      mask_sh_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      an_q        <= AN_OFF;
      cath_q      <= CATH_OFF;
      fs_q        <= 1'b0;
    end else begin
      seg_sh_q    <= seg_sh_d;
      mask_sh_q   <= mask_sh_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      an_q        <= an_d;
      cath_q      <= cath_d;
      fs_q        <= fs_d;
    end
  end

  assign an          = an_q;
  assign cathode     = cath_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: time-based reference model plus
// directed literal checks and randomized stimulus.
module tb_seg_display_scanner;

  localparam int DC = 8;
  localparam int GC = 2;
  localparam int BF = 2;
  localparam int FR = 4 * DC;
  localparam logic [27:0] SEG1234 =
    {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [27:0] seg_array = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  cathode;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  seg_display_scanner #(
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(GC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .seg_array  (seg_array),
    .blink_mask (blink_mask),
    .an         (an),
    .cathode    (cathode),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since the scan (re)started.
  int          t = 0;
  int          m_fc = 0;
  int          pos, dig;
  logic [27:0] m_seg = '0;
  logic [3:0]  m_mask = '0;
  bit          m_ph = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_cath = 7'h7F;
  logic        e_fs = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t = 0; m_fc = 0; m_seg = '0; m_mask = '0; m_ph = 1'b0;
      e_an = 4'hF; e_cath = 7'h7F; e_fs = 1'b0;
    end else if (!enable) begin
      t = 0; m_fc = 0;
      e_an = 4'hF; e_cath = 7'h7F; e_fs = 1'b0;
    end else begin
      pos = t % DC;
      dig = t / DC;
      e_fs = (t == 0);
      if (t == 0) begin
        m_seg  = seg_array;
        m_mask = blink_mask;
      end
      e_cath = ~m_seg[27 - 7*dig -: 7];
      if (pos >= GC && !(m_mask[3-dig] && m_ph))
        e_an = ~(4'b1000 >> dig);
      else
        e_an = 4'hF;
      t++;
      if (t == FR) begin
        t = 0;
        m_fc++;
        if (m_fc == BF) begin
          m_fc = 0;
          m_ph = ~m_ph;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("an", an, e_an);
    chk("cathode", cathode, e_cath);
    chk("frame_start", frame_start, e_fs);
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  int edge_n = 0;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    edge_n += n;
  endtask

  task automatic step_to(input int e);
    step(e - edge_n);
  endtask

  initial begin
    step(3);
    chk("rst_an", an, 4'hF);
    chk("rst_cath", cathode, 7'h7F);
    chk("rst_fs", frame_start, 1'b0);

    seg_array  = SEG1234;
    blink_mask = 4'b0100;
    enable     = 1'b1;
    resetn     = 1'b1;
    edge_n     = 0;

    step_to(1);
    chk("first_fs", frame_start, 1'b1);
    chk("first_guard", an, 4'hF);
    chk("d0_cath", cathode, 7'h79);
    step_to(2);
    chk("fs_pulse_end", frame_start, 1'b0);
    chk("guard2", an, 4'hF);
    step_to(3);
    chk("d0_lit", an, 4'b0111);
    step_to(8);
    chk("d0_last", an, 4'b0111);
    step_to(9);
    chk("d1_guard", an, 4'hF);
    chk("d1_cath", cathode, 7'h24);
    step_to(10);
    seg_array = 28'hFFFFFFF;
    step_to(11);
    chk("d1_lit", an, 4'b1011);
    step_to(17);
    chk("tear_d2", cathode, 7'h30);
    step_to(25);
    chk("tear_d3", cathode, 7'h19);
    step_to(33);
    chk("f1_fs", frame_start, 1'b1);
    chk("f1_cath", cathode, 7'h00);
    step_to(75);
    chk("blink_dark", an, 4'hF);
    step_to(83);
    chk("blink_other", an, 4'b1101);
    step_to(139);
    chk("blink_back", an, 4'b1011);

    step_to(149);
    enable = 1'b0;
    step_to(150);
    chk("dis_an", an, 4'hF);
    chk("dis_cath", cathode, 7'h7F);
    step_to(153);
    enable = 1'b1;
    step_to(154);
    chk("reen_fs", frame_start, 1'b1);
    step_to(156);
    chk("reen_lit", an, 4'b0111);

    step_to(165);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_cath", cathode, 7'h7F);
    chk("async_fs", frame_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
    step_to(1);
    chk("rel_fs", frame_start, 1'b1);
    step_to(3);
    chk("rel_lit", an, 4'b0111);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) seg_array = 28'($urandom);
      if ($urandom_range(15) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(150) == 0) enable = ~enable;
      else if (!enable && $urandom_range(5) == 0) enable = 1'b1;
      if ($urandom_range(700) == 0) resetn = 1'b0;
      else resetn = 1'b1;
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.
- Sits directly downstream of the number-to-segment conversion.
- Consumes the packed 28-bit active-high segment array (digit 0 = leftmost = bits [27:21]) and produces registered active-low anode and cathode pins.
- Adds per-digit blinking for edit-position feedback, a ghosting guard interval, and frame-coherent snapshotting so the display never shows a torn value.

Parameters:
- DIGIT_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- GUARD_CYCLES, 2000, cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES.
- BLINK_FRAMES, 125, frames per blink half-period (~0.5 s at 4 ms frames); must be >= 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset; asynchronous, active-low
- enable  input  1  1 = scan active; 0 = display dark
- seg_array  input  28  active-high gfedcba patterns; [27:21] digit0 (left) .. [6:0] digit3 (right)
- blink_mask  input  4  bit3 = digit0 .. bit0 = digit3; 1 = digit blinks
- an  output  4  active-low anodes; an[3] = digit0 (left) .. an[0] = digit3
- cathode  output  7  active-low segments {g,f,e,d,c,b,a}
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (async, resetn=0):
  - Outputs: an=4'b1111, cathode=7'h7F, frame_start=0.
  - Internal state: slot counter=0, digit index=0, blink counter=0, blink_phase=0, shadow registers=0.
  - Reset asserted mid-frame forces the same state immediately.
- Slot counter: counts 0..DIGIT_CYCLES-1 then wraps to 0. On wrap, digit index advances 0→1→2→3→0.
- Snapshot: in the cycle where slot counter=0, digit index=0 and enable=1:
  - seg_array and blink_mask are latched into shadow registers.
  - frame_start is asserted on the next edge, for one cycle.
  - Input changes at any other time are ignored until the next frame.
- Per-slot states (derived from counter, no separate FSM register required):
  - GUARD: counter < GUARD_CYCLES; all anodes off.
  - ON: otherwise; the selected anode is low unless that digit is blanked.
- Blanking: a digit is blanked when its shadow blink bit = 1 and blink_phase = 1.
  - A blanked digit keeps its anode high for the whole slot.
  - Cathode still carries the inverted pattern.
- Blink counter: increments at each frame wrap (digit 3 → 0). On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
- Same-edge toggle and snapshot: when a blink_phase toggle and a snapshot fall on the same edge, the new phase applies to the frame being latched.
- Cathode: cathode = ~shadow pattern of the current digit, updated at the slot boundary.
- Latency: outputs are registered, one cycle after internal state.
  - First visible anode after reset release with enable=1: cycle GUARD_CYCLES+1.
- enable=0:
  - On the next edge: an=4'b1111, cathode=7'h7F; counters, index and blink counter clear.
  - blink_phase holds.
  - Re-enabling restarts at digit 0 with a fresh snapshot on the first enabled cycle.
- Invariant: at most one an bit is low in any cycle, including across slot wraps and enable edges.

Decomposition:
- Shared package holds:
  - Digit index type (2-bit).
  - Anode one-hot constants AN_OFF=4'b1111, AN_D0=4'b0111, AN_D1=4'b1011, AN_D2=4'b1101, AN_D3=4'b1110.
  - CATH_OFF=7'h7F.
- One sub-module is natural: scan_prescaler.
  - Holds the slot counter and the digit-index/frame-wrap generator.
  - Outputs slot_zero, in_guard, digit_idx, frame_wrap.
- Blink, snapshot and output registers stay in the top module.

Test Plan:
Bench uses DIGIT_CYCLES=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
1. Basic scan: "1234" patterns (0000110, 1011011, 1001111, 1100110), enable=1 → an cycles 0111, 1011, 1101, 1110 with 6 on-cycles each; cathode 7'h79, 7'h24, 7'h30, 7'h19; frame_start every 32 cycles.
2. Tear check: change seg_array to "8888" during digit 1 → remaining digits of that frame still show "1234"; the next frame shows all cathodes = 7'h00.
3. Blink: blink_mask=4'b0100 → digit1 anode stays high in frames 2–3 and lit in frames 0–1 and 4–5; other digits are unaffected.
4. Guard: scoreboard every cycle → an=1111 for the first 2 cycles of every slot; never more than one low bit.
5. Enable drop: enable=0 mid-digit2 → next cycle an=1111, cathode=7'h7F; re-enable → digit0 lights at cycle 3 after enable, and frame_start pulses.
6. Async reset: pull resetn low mid-slot between clock edges → outputs take reset values immediately; resume from digit 0 after release.
